counter_mod_prog: RTL

Runtime-programmable modulo counter and frequency divider, successor to the fixed-modulus divider used for cache controller wait-state and refill-beat timing. Adds runtime modulus reprogramming through a shadow register, up/down counting, parallel load, and a one-shot mode with a start/done handshake. Sits beside the cache FSM, which uses it to time memory latency and burst beats.

---
 rtl/counter_pkg.sv | 32 +++
 rtl/counter_prescaler.sv | 34 +++
 rtl/counter_mod_prog.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types, constants and clamp helpers for the programmable modulo counter.
// Contents:
//   state_t        one-shot FSM states (IDLE, RUN, DONE)
//   DIR_UP/DOWN    values of the dir input
//   clamp_mod      forces a modulus of zero up to one
//   clamp_load     limits a load value to the active modulus minus one
package counter_pkg;

    localparam int unsigned MAX_W = 16;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A modulus of zero has no meaning; treat it as a divide-by-one.
    function automatic word_t clamp_mod(input word_t v);
        return (v == '0) ? MAX_W'(1) : v;
    endfunction

    // Keep a loaded count inside the range 0..m-1 (m is never zero).
    function automatic word_t clamp_load(input word_t v, input word_t m);
        return (v >= m) ? (m - MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for the programmable modulo counter; built only with COUNTER_PRESCALE_EN.
// Ports:
//   clk, r_n  clock and synchronous active-low reset
//   clr       synchronous clear of the prescale count
//   inc       qualified count enable from the parent
//   pre       prescale terminal value (divide by pre+1)
//   hit_c     combinational: prescale count has reached pre
module counter_prescaler #(
    parameter int unsigned PW = 4
) (
    input  logic          clk,
    input  logic          r_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [PW-1:0] pre,
    output logic          hit_c
);

    logic [PW-1:0] p;

    assign hit_c = (p == pre);

    // Count qualified enables; restart after each hit so the parent ticks every pre+1 enables.
    always_ff @(posedge clk) begin
        if (!r_n) begin
            p <= '0;
        end else if (clr) begin
            p <= '0;
        end else if (inc) begin
            p <= hit_c ? '0 : (p + PW'(1));
        end
    end

endmodule

// File: rtl/counter_mod_prog.sv
// Runtime-programmable modulo counter / frequency divider with up/down count,
// parallel load, shadowed modulus and a one-shot start/done mode.
// Optional feature macro: COUNTER_PRESCALE_EN (adds the pre input and a prescaler).
// Ports:
//   clk, r_n        clock and synchronous active-low reset
//   pre             prescale value (only with COUNTER_PRESCALE_EN)
//   en, dir         count enable; 1 = up, 0 = down
//   oneshot, start  one-shot mode select and trigger
//   ld, ld_val      parallel load strobe and value
//   mod_wr, mod_in  shadow modulus write strobe and value
//   co              terminal-count tick (combinational)
//   q               current count
//   busy, done      one-shot run in progress / completion pulse
module counter_mod_prog
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DEFAULT_MOD = 10,
    parameter int unsigned PW          = 4
) (
    input  logic             clk,
    input  logic             r_n,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PW-1:0]    pre,
`endif
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             start,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_in,
    output logic             co,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] RST_MOD = WIDTH'(DEFAULT_MOD);

    // Elaboration-time guard on the parameter ranges.
    if (WIDTH < 2 || WIDTH > MAX_W || DEFAULT_MOD < 1 ||
        DEFAULT_MOD >= (32'd1 << WIDTH) || PW < 1) begin : g_param_check
        $error("counter_mod_prog: parameter out of range");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] m, m_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] wrap_val;
    logic             at_term;
    logic             start_ok;
    logic             qual;
    logic             pre_hit;
    logic             tick;

    // Start is accepted only in one-shot mode, outside RUN, and loses to a load.
    assign start_ok = oneshot && start && !ld && (state != RUN);

    // Enable qualified by reset, load priority and the mode/state combination.
    assign qual = r_n && en && !ld && (oneshot ? (state == RUN) : (state == IDLE));

`ifdef COUNTER_PRESCALE_EN
    logic p_clr;

    assign p_clr = ld || start_ok || ((state == RUN) && (state_n != RUN));

    counter_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk   (clk),
        .r_n   (r_n),
        .clr   (p_clr),
        .inc   (qual),
        .pre   (pre),
        .hit_c (pre_hit)
    );
`else
    assign pre_hit = 1'b1;
`endif

    assign tick     = qual && pre_hit;
    assign term     = (dir == DIR_UP) ? (m - WIDTH'(1)) : '0;
    assign at_term  = (q == term);
    assign co       = tick && at_term;
    // Wrap/start target uses the shadow, since the shadow transfers on the same edge.
    assign wrap_val = (dir == DIR_DOWN) ? (shadow - WIDTH'(1)) : '0;

    // Next count, modulus, shadow and FSM state.
    always_comb begin
        state_n  = state;
        q_n      = q;
        m_n      = m;
        shadow_n = mod_wr ? WIDTH'(clamp_mod(MAX_W'(mod_in))) : shadow;

        if (ld) begin
            m_n = shadow;
            q_n = WIDTH'(clamp_load(MAX_W'(ld_val), MAX_W'(shadow)));
        end else if (start_ok) begin
            m_n = shadow;
            q_n = wrap_val;
        end else if (tick) begin
            if (at_term) begin
                m_n = shadow;
                q_n = wrap_val;
            end else if (dir == DIR_UP) begin
                q_n = q + WIDTH'(1);
            end else begin
                q_n = q - WIDTH'(1);
            end
        end

        if (!oneshot) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_n = RUN;
                RUN:     if (tick && at_term) state_n = DONE;
                DONE:    state_n = start_ok ? RUN : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!r_n) begin
            state  <= IDLE;
            q      <= '0;
            m      <= RST_MOD;
            shadow <= RST_MOD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            m      <= m_n;
            shadow <= shadow_n;
            busy   <= (state_n == RUN);
            done   <= (state_n == DONE);
        end
    end

endmodule
